sdram_init_seq: RTL and testbench
=================================

# sdram_init_seq

Power-up initialisation sequencer for the board SDRAM, in the memory clock domain, directly downstream of the clocks/resets block. Waits for that block's SDRAM enable, then drives CKE and the JEDEC init sequence: power-up wait, precharge-all, N auto-refreshes, load mode register. Raises `o_memory_initialized`, which the clocks/resets block uses to release system ready. Once done, the mux hands the command bus to the run-time SDRAM controller.

## Interface
- `T_POWERUP`, 8000: power-up wait in clocks, 100 µs at 80 MHz; range 16..65535.
- `T_RP`, 2: precharge-to-next-command clocks; range 1..255.
- `T_RFC`, 7: refresh-to-next-command clocks; range 1..255.
- `T_MRD`, 2: mode-register-to-done clocks; range 1..255.
- `N_REFRESH`, 2: auto-refresh count; range 1..15.
- `MODE_REG`, 13'h0022: value driven on address during LOAD_MODE (CAS 2, burst 4, sequential).
- `i_mem_clk` input 1: memory clock, 80 MHz; all logic on its rising edge.
- `i_mem_rst_n` input 1: asynchronous active-low reset.
- `i_sdr_ena` input 1: start request, synchronous to `i_mem_clk`; sampled only in IDLE.
- `o_sdr_cke` output 1: SDRAM clock enable.
- `o_sdr_cmd` output 4: {cs_n, ras_n, cas_n, we_n}.
- `o_sdr_addr` output 13: SDRAM address.
- `o_sdr_ba` output 2: bank address, always 0.
- `o_memory_initialized` output 1: sequence complete, sticky.

## Operation
- Command encodings: INHIBIT 4'b1111, NOP 4'b0111, PRECHARGE 4'b0010, REFRESH 4'b0001, LOAD_MODE 4'b0000.
- Reset values: cke 0, cmd INHIBIT, addr 0, ba 0, initialized 0, state IDLE, counters 0.
- All outputs are registered. Default cmd is NOP in any state other than IDLE and DONE.
- States:
  - IDLE: cmd INHIBIT. Go to POWERUP when `i_sdr_ena`=1.
  - POWERUP: cke=1. Count T_POWERUP cycles, then go to PRE.
  - PRE: one cycle, cmd PRECHARGE, addr[10]=1, other address bits 0. Go to WAIT_RP.
  - WAIT_RP: NOPs until T_RP cycles after PRE. Go to REF.
  - REF: one cycle, cmd REFRESH. Increment the refresh counter. Go to WAIT_RFC.
  - WAIT_RFC: NOPs until T_RFC cycles after REF. Go to REF if fewer than N_REFRESH refreshes have been issued, else go to LMR.
  - LMR: one cycle, cmd LOAD_MODE, addr=MODE_REG, ba=0. Go to WAIT_MRD.
  - WAIT_MRD: NOPs until T_MRD cycles after LMR. Go to DONE.
  - DONE: cmd NOP, cke=1, initialized=1. Terminal state; only reset leaves it.
- Counters:
  - Wait counter is 16 bits, reloaded at each state entry, counting down to 1.
  - Refresh counter is 4 bits, cleared in IDLE.
- Address is 0 in all cycles except PRE and LMR.
- Once the block leaves IDLE, `i_sdr_ena` is ignored; its deassertion mid-sequence has no effect.
- Reset asserted mid-sequence: all outputs return to their reset values asynchronously. After release the sequence restarts from IDLE, including the full power-up wait.

## Timing
- Cycle 0 is the edge that samples `i_sdr_ena`=1 in IDLE.
- Cycle 1: cke=1, cmd NOP.
- PRECHARGE at cycle 1+T_POWERUP.
- REFRESH k (k=0..N_REFRESH-1) at cycle 1+T_POWERUP+T_RP+k·T_RFC.
- LOAD_MODE at cycle L = 1+T_POWERUP+T_RP+N_REFRESH·T_RFC.
- `o_memory_initialized` rises at cycle L+T_MRD and stays high until reset.
- Each command is exactly one cycle wide. No two commands are closer together than their T parameter.

## Configuration
- Macro `SDR_INIT_FAST_SIM_EN`.
- Defined: the power-up wait is fixed at 16 cycles regardless of T_POWERUP. For simulation only.
- Undefined: T_POWERUP is used as specified.
- All other timing is unchanged in both cases.

## Test plan
All scenarios use T_POWERUP=20, T_RP=2, T_RFC=7, T_MRD=2, N_REFRESH=2, macro undefined, unless stated otherwise.

1. Nominal: `i_sdr_ena`=1 at cycle 0 → cke=1 at cycle 1; PRECHARGE with addr=13'h0400 at cycle 21; REFRESH at cycles 23 and 30; LOAD_MODE with addr=13'h0022 at cycle 37; `o_memory_initialized`=1 from cycle 39 onward; NOP on every other cycle.
2. Idle hold: `i_sdr_ena` held 0 for 1000 cycles → cmd stays 4'b1111, cke=0, initialized=0.
3. Enable dropped: `i_sdr_ena` pulsed high for 1 cycle at cycle 0 → command timing identical to scenario 1.
4. Mid-sequence reset: `i_mem_rst_n` low at cycle 25 → cke=0 and cmd=INHIBIT immediately (asynchronous). After release and `i_sdr_ena`=1, full sequence repeats with scenario 1 timing relative to the new cycle 0.
5. With `SDR_INIT_FAST_SIM_EN` defined and T_POWERUP=8000: PRECHARGE at cycle 17; initialized at cycle 35.
6. N_REFRESH=8, T_RFC=10 → exactly 8 REFRESH commands, spaced 10 cycles apart; LOAD_MODE at cycle 103.

Source files
------------

// File: rtl/sdram_init_seq.sv
// Power-up initialisation sequencer for the board SDRAM: CKE, power-up wait, precharge-all,
// N auto-refreshes, load mode register. Define SDR_INIT_FAST_SIM_EN to shorten the power-up wait to 16 cycles.
module sdram_init_seq #(
   parameter int          T_POWERUP = 8000,
   parameter int          T_RP      = 2,
   parameter int          T_RFC     = 7,
   parameter int          T_MRD     = 2,
   parameter int          N_REFRESH = 2,
   parameter logic [12:0] MODE_REG  = 13'h0022
) (
   input  logic        i_mem_clk,
   input  logic        i_mem_rst_n,
   input  logic        i_sdr_ena,
   output logic        o_sdr_cke,
   output logic [3:0]  o_sdr_cmd,
   output logic [12:0] o_sdr_addr,
   output logic [1:0]  o_sdr_ba,
   output logic        o_memory_initialized
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_POWERUP,
      ST_PRE,
      ST_WAIT_RP,
      ST_REF,
      ST_WAIT_RFC,
      ST_LMR,
      ST_WAIT_MRD,
      ST_DONE
   } state_t;

   localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;
   localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

`ifdef SDR_INIT_FAST_SIM_EN
   localparam logic [15:0] PU_CYCLES = 16'd16;
`else
   localparam logic [15:0] PU_CYCLES = 16'(T_POWERUP);
`endif
   localparam logic [15:0] RP_CYCLES  = 16'(T_RP);
   localparam logic [15:0] RFC_CYCLES = 16'(T_RFC);
   localparam logic [15:0] MRD_CYCLES = 16'(T_MRD);
   localparam logic [3:0]  NREF       = 4'(N_REFRESH);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt, wait_cnt_nxt;
   logic [3:0]  ref_cnt, ref_cnt_nxt;
   logic [3:0]  refs_issued;
   logic        wait_done;
   logic        cke_nxt;
   logic [3:0]  cmd_nxt;
   logic [12:0] addr_nxt;
   logic        init_nxt;

   // The wait counter is loaded when a command state is entered and keeps running through
   // the following wait state, so a T value of 1 skips the wait state entirely.
   assign wait_done   = (wait_cnt == 16'd1);
   assign refs_issued = (state == ST_REF) ? ref_cnt + 4'd1 : ref_cnt;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = (wait_cnt != 16'd0) ? wait_cnt - 16'd1 : 16'd0;
      ref_cnt_nxt  = ref_cnt;
      case (state)
         ST_IDLE: begin
            ref_cnt_nxt  = 4'd0;
            wait_cnt_nxt = 16'd0;
            if (i_sdr_ena) begin
               state_nxt    = ST_POWERUP;
               wait_cnt_nxt = PU_CYCLES;
            end
         end
         ST_POWERUP: begin
            if (wait_done) begin
               state_nxt    = ST_PRE;
               wait_cnt_nxt = RP_CYCLES;
            end
         end
         ST_PRE, ST_WAIT_RP: begin
            if (wait_done) begin
               state_nxt    = ST_REF;
               wait_cnt_nxt = RFC_CYCLES;
            end else begin
               state_nxt = ST_WAIT_RP;
            end
         end
         ST_REF, ST_WAIT_RFC: begin
            if (state == ST_REF) begin
               ref_cnt_nxt = ref_cnt + 4'd1;
            end
            if (!wait_done) begin
               state_nxt = ST_WAIT_RFC;
            end else if (refs_issued < NREF) begin
               state_nxt    = ST_REF;
               wait_cnt_nxt = RFC_CYCLES;
            end else begin
               state_nxt    = ST_LMR;
               wait_cnt_nxt = MRD_CYCLES;
            end
         end
         ST_LMR, ST_WAIT_MRD: begin
            if (wait_done) begin
               state_nxt    = ST_DONE;
               wait_cnt_nxt = 16'd0;
            end else begin
               state_nxt = ST_WAIT_MRD;
            end
         end
         ST_DONE: begin
            wait_cnt_nxt = 16'd0;
         end
         default: begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = 16'd0;
         end
      endcase
   end

   // Output values are decoded from the current state and registered one cycle later.
   always_comb begin
      cke_nxt  = (state != ST_IDLE);
      cmd_nxt  = CMD_NOP;
      addr_nxt = 13'd0;
      init_nxt = (state == ST_DONE);
      case (state)
         ST_IDLE: cmd_nxt = CMD_INHIBIT;
         ST_PRE: begin
            cmd_nxt  = CMD_PRECHARGE;
            addr_nxt = 13'h0400;
         end
         ST_REF: cmd_nxt = CMD_REFRESH;
         ST_LMR: begin
            cmd_nxt  = CMD_LOAD_MODE;
            addr_nxt = MODE_REG;
         end
         default: cmd_nxt = CMD_NOP;
      endcase
   end

   always_ff @(posedge i_mem_clk or negedge i_mem_rst_n) begin
      if (!i_mem_rst_n) begin
         state                <= ST_IDLE;
         wait_cnt             <= 16'd0;
         ref_cnt              <= 4'd0;
         o_sdr_cke            <= 1'b0;
         o_sdr_cmd            <= CMD_INHIBIT;
         o_sdr_addr           <= 13'd0;
         o_memory_initialized <= 1'b0;
      end else begin
         state                <= state_nxt;
         wait_cnt             <= wait_cnt_nxt;
         ref_cnt              <= ref_cnt_nxt;
         o_sdr_cke            <= cke_nxt;
         o_sdr_cmd            <= cmd_nxt;
         o_sdr_addr           <= addr_nxt;
         o_memory_initialized <= init_nxt;
      end
   end

   assign o_sdr_ba = 2'b00;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq: expected output words are queued when a sequence is started
// and popped one per clock; two instances cover the nominal and the long-refresh configurations.
module tb_sdram_init_seq;

   localparam int T_RP  = 2;
   localparam int T_MRD = 2;
`ifdef SDR_INIT_FAST_SIM_EN
   localparam int PU_MODEL = 16;
`else
   localparam int PU_MODEL = 20;
`endif

   logic        clk = 1'b0;
   logic        rst_a_n, ena_a, rst_b_n, ena_b;
   logic        cke_a, init_a, cke_b, init_b;
   logic [3:0]  cmd_a, cmd_b;
   logic [12:0] addr_a, addr_b;
   logic [1:0]  ba_a, ba_b;
   logic [20:0] obs_a, obs_b;
   logic [20:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   sdram_init_seq #(
      .T_POWERUP(20), .T_RP(2), .T_RFC(7), .T_MRD(2), .N_REFRESH(2), .MODE_REG(13'h0022)
   ) dut_a (
      .i_mem_clk(clk), .i_mem_rst_n(rst_a_n), .i_sdr_ena(ena_a),
      .o_sdr_cke(cke_a), .o_sdr_cmd(cmd_a), .o_sdr_addr(addr_a), .o_sdr_ba(ba_a),
      .o_memory_initialized(init_a)
   );

   sdram_init_seq #(
      .T_POWERUP(20), .T_RP(2), .T_RFC(10), .T_MRD(2), .N_REFRESH(8), .MODE_REG(13'h0022)
   ) dut_b (
      .i_mem_clk(clk), .i_mem_rst_n(rst_b_n), .i_sdr_ena(ena_b),
      .o_sdr_cke(cke_b), .o_sdr_cmd(cmd_b), .o_sdr_addr(addr_b), .o_sdr_ba(ba_b),
      .o_memory_initialized(init_b)
   );

   assign obs_a = {init_a, cke_a, ba_a, cmd_a, addr_a};
   assign obs_b = {init_b, cke_b, ba_b, cmd_b, addr_b};

   // Expected {init, cke, ba, cmd, addr} at cycle n, built from the command timetable.
   function automatic logic [20:0] model(input int n, input int rfc, input int nref);
      int          l;
      logic [3:0]  cmd;
      logic [12:0] addr;
      if (n <= 0) return {1'b0, 1'b0, 2'b00, 4'b1111, 13'h0000};
      l    = 1 + PU_MODEL + T_RP + nref * rfc;
      cmd  = 4'b0111;
      addr = 13'h0000;
      if (n == 1 + PU_MODEL) begin
         cmd  = 4'b0010;
         addr = 13'h0400;
      end else if (n == l) begin
         cmd  = 4'b0000;
         addr = 13'h0022;
      end else begin
         for (int k = 0; k < nref; k++)
            if (n == 1 + PU_MODEL + T_RP + k * rfc) cmd = 4'b0001;
      end
      return {(n >= l + T_MRD), 1'b1, 2'b00, cmd, addr};
   endfunction

   function automatic logic [20:0] observed(input int sel);
      return (sel != 0) ? obs_b : obs_a;
   endfunction

   task automatic checkOutput(input string tag, input logic [20:0] got, input logic [20:0] expected);
      vectors++;
      if (got !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
      end
   endtask

   task automatic set_ena(input int sel, input logic v);
      if (sel != 0) ena_b = v;
      else ena_a = v;
   endtask

   task automatic set_rst(input int sel, input logic v);
      if (sel != 0) rst_b_n = v;
      else rst_a_n = v;
   endtask

   task automatic reset_dut(input int sel);
      @(negedge clk);
      set_ena(sel, 1'b0);
      set_rst(sel, 1'b0);
      exp_q.push_back(model(0, 7, 2));
      @(negedge clk);
      checkOutput($sformatf("rst%0d", sel), observed(sel), exp_q.pop_front());
      set_rst(sel, 1'b1);
   endtask

   // Starts a sequence (enable held or pulsed for one cycle); reset_at >= 0 asserts reset after that cycle.
   task automatic applyStimulus(input int sel, input bit pulse, input int reset_at);
      int rfc, nref, last;
      rfc  = (sel != 0) ? 10 : 7;
      nref = (sel != 0) ? 8 : 2;
      last = 1 + PU_MODEL + T_RP + nref * rfc + T_MRD + 3;
      @(negedge clk);
      set_ena(sel, 1'b1);
      for (int n = 0; n <= last; n++) exp_q.push_back(model(n, rfc, nref));
      for (int n = 0; n <= last; n++) begin
         @(posedge clk);
         #1;
         if (pulse) set_ena(sel, 1'b0);
         checkOutput($sformatf("s%0d_c%0d", sel, n), observed(sel), exp_q.pop_front());
         if (n == reset_at) begin
            #2;
            exp_q.delete();
            exp_q.push_back(model(0, rfc, nref));
            set_rst(sel, 1'b0);
            #1;
            checkOutput($sformatf("async_rst%0d_c%0d", sel, n), observed(sel), exp_q.pop_front());
            set_ena(sel, 1'b0);
            @(negedge clk);
            set_rst(sel, 1'b1);
            return;
         end
      end
      set_ena(sel, 1'b0);
   endtask

   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      ena_a   = 1'b0;
      ena_b   = 1'b0;
      #12;
      exp_q.push_back(model(0, 7, 2));
      exp_q.push_back(model(0, 10, 8));
      checkOutput("reset_a", obs_a, exp_q.pop_front());
      checkOutput("reset_b", obs_b, exp_q.pop_front());
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Idle hold: enable low, nothing may leave the INHIBIT state.
      for (int n = 0; n < 1000; n++) begin
         exp_q.push_back(model(0, 7, 2));
         @(posedge clk);
         #1;
         checkOutput($sformatf("idle_c%0d", n), obs_a, exp_q.pop_front());
      end

      applyStimulus(0, 1'b0, -1);
      reset_dut(0);
      applyStimulus(0, 1'b1, -1);
      reset_dut(0);
      applyStimulus(0, 1'b0, 25);
      applyStimulus(0, 1'b0, -1);
      applyStimulus(1, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      miscompares++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
